// File: rtl/ps2_pkg.sv
// ============================================================================
// Package  : ps2_pkg
// Brief    : Shared PS/2 transmitter types, frame constants and helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XMIT    = 2'd1,
        ST_GAP     = 2'd2,
        ST_INHIBIT = 2'd3
    } ps2_state_e;

    localparam int FRAME_BITS   = 11;
    localparam int GAP_HALVES   = 2;
    localparam int FRAME_HALVES = 2 * FRAME_BITS;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Bit k of the result is the k-th bit on the wire (start first).
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_tx_fifo.sv
// ============================================================================
// Module   : ps2_tx_fifo
// Brief    : Byte FIFO with registered full/level and sticky overflow flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_tx_fifo #(
    parameter int FIFO_BITS = 3
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    input  logic                 rd_en,
    input  logic                 clr_overflow,
    output logic [7:0]           rd_data,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic [FIFO_BITS:0]   level
);

    localparam int                 C_DEPTH      = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS:0] C_FULL_LEVEL = (FIFO_BITS + 1)'(C_DEPTH);

    logic [7:0]           mem_q [C_DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_BITS:0]   level_q, level_d;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic                 w_push, w_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign w_pop  = rd_en && (level_q != '0);
    assign w_push = wr_en && (!full_q || w_pop);

    always_comb begin
        wr_ptr_d   = w_push ? wr_ptr_q + FIFO_BITS'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + FIFO_BITS'(1) : rd_ptr_q;
        level_d    = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d     = (level_d == C_FULL_LEVEL);
        overflow_d = (overflow_q && !clr_overflow) || (wr_en && !w_push);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign empty    = (level_q == '0);
    assign full     = full_q;
    assign overflow = overflow_q;
    assign level    = level_q;

endmodule

`default_nettype wire

// File: rtl/ps2_dev_tx.sv
// ============================================================================
// Module   : ps2_dev_tx
// Brief    : PS/2 device-side transmitter: FIFO, bit-rate divider, framing FSM
//            and host-inhibit detection with full-frame retransmission
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_dev_tx
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS      = 3,
    parameter int CLK_DIV        = 100,
    parameter int INHIBIT_FILTER = 4
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    input  logic                 ps2_clk_in,
    input  logic                 clr_overflow,
    output logic                 ps2_clk_out,
    output logic                 ps2_data_out,
    output logic                 full,
    output logic [FIFO_BITS:0]   level,
    output logic                 overflow,
    output logic                 busy
);

    localparam int                 C_DIV_W     = $clog2(CLK_DIV);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST  = C_DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]         C_FILT      = 4'(INHIBIT_FILTER);
    localparam logic [4:0]         C_LAST_HALF = 5'(FRAME_HALVES - 1);
    localparam logic [4:0]         C_STOP_HALF = 5'(FRAME_HALVES - 2);
    localparam logic [4:0]         C_GAP_LAST  = 5'(GAP_HALVES - 1);

    ps2_state_e           state_q, state_d;
    logic [C_DIV_W-1:0]   div_q, div_d;
    logic [4:0]           half_q, half_d;
    logic                 clk_out_q, clk_out_d;
    logic                 data_out_q, data_out_d;
    logic [1:0]           sync_q, sync_d;
    logic [3:0]           lo_cnt_q, lo_cnt_d;
    logic [3:0]           hi_cnt_q, hi_cnt_d;

    logic                 w_pop, w_empty, w_inhibit, w_div_end;
    logic [7:0]           w_head;
    logic [FRAME_BITS-1:0] w_frame;
    logic [3:0]           w_next_bit;

    ps2_tx_fifo #(
        .FIFO_BITS   (FIFO_BITS)
    ) u_fifo (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (w_pop),
        .clr_overflow(clr_overflow),
        .rd_data     (w_head),
        .empty       (w_empty),
        .full        (full),
        .overflow    (overflow),
        .level       (level)
    );

    assign w_frame    = build_frame(w_head);
    assign w_next_bit = 4'((half_q + 5'd1) >> 1);
    assign w_div_end  = (div_q == C_DIV_LAST);
    assign w_inhibit  = (lo_cnt_q == C_FILT);

    // Host clock is only trusted while our own clock drives high; during
    // low half-bits the wired line reads back low regardless of the host.
    always_comb begin
        sync_d   = {sync_q[0], ps2_clk_in};
        lo_cnt_d = lo_cnt_q;
        if (clk_out_q) begin
            if (sync_q[1])
                lo_cnt_d = '0;
            else if (lo_cnt_q != C_FILT)
                lo_cnt_d = lo_cnt_q + 4'd1;
        end
        hi_cnt_d = '0;
        if (state_q == ST_INHIBIT && sync_q[1])
            hi_cnt_d = (hi_cnt_q == C_FILT) ? hi_cnt_q : hi_cnt_q + 4'd1;
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        half_d     = half_q;
        clk_out_d  = clk_out_q;
        data_out_d = data_out_q;
        w_pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_d      = '0;
                half_d     = '0;
                clk_out_d  = 1'b1;
                data_out_d = 1'b1;
                if (w_inhibit) begin
                    state_d = ST_INHIBIT;
                end else if (!w_empty) begin
                    state_d    = ST_XMIT;
                    data_out_d = w_frame[0];
                end
            end
            ST_XMIT: begin
                if (w_inhibit && clk_out_q && half_q < C_STOP_HALF) begin
                    state_d    = ST_INHIBIT;
                    div_d      = '0;
                    half_d     = '0;
                    clk_out_d  = 1'b1;
                    data_out_d = 1'b1;
                end else if (w_div_end) begin
                    div_d = '0;
                    if (half_q == C_LAST_HALF) begin
                        w_pop      = 1'b1;
                        state_d    = ST_GAP;
                        half_d     = '0;
                        clk_out_d  = 1'b1;
                        data_out_d = 1'b1;
                    end else begin
                        half_d    = half_q + 5'd1;
                        clk_out_d = half_q[0];
                        if (half_q[0])
                            data_out_d = w_frame[w_next_bit];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_GAP: begin
                clk_out_d  = 1'b1;
                data_out_d = 1'b1;
                if (w_inhibit) begin
                    state_d = ST_INHIBIT;
                    div_d   = '0;
                    half_d  = '0;
                end else if (w_div_end) begin
                    div_d = '0;
                    if (half_q == C_GAP_LAST) begin
                        half_d = '0;
                        // Chaining straight into the next start bit keeps
                        // back-to-back frames on a 24-half-bit period.
                        if (!w_empty) begin
                            state_d    = ST_XMIT;
                            data_out_d = w_frame[0];
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        half_d = half_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_INHIBIT: begin
                div_d      = '0;
                half_d     = '0;
                clk_out_d  = 1'b1;
                data_out_d = 1'b1;
                if (hi_cnt_q == C_FILT)
                    state_d = ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            half_q     <= '0;
            clk_out_q  <= 1'b1;
            data_out_q <= 1'b1;
            sync_q     <= 2'b11;
            lo_cnt_q   <= '0;
            hi_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            half_q     <= half_d;
            clk_out_q  <= clk_out_d;
            data_out_q <= data_out_d;
            sync_q     <= sync_d;
            lo_cnt_q   <= lo_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
        end
    end

    assign ps2_clk_out  = clk_out_q;
    assign ps2_data_out = data_out_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ps2_dev_tx.sv
// ============================================================================
// Module   : tb_ps2_dev_tx
// Brief    : Self-checking bench: decodes frames off the lines and compares
//            them with bytes pushed, plus FIFO, inhibit and reset scenarios
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_dev_tx;

    localparam int FB = 2;
    localparam int C  = 4;
    localparam int F  = 4;

    logic         clk_sys = 1'b0;
    logic         reset = 1'b1;
    logic         wr_en = 1'b0;
    logic [7:0]   wr_data = 8'h00;
    logic         ps2_clk_in = 1'b1;
    logic         clr_overflow = 1'b0;
    logic         ps2_clk_out, ps2_data_out, full, overflow, busy;
    logic [FB:0]  level;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    ps2_dev_tx #(.FIFO_BITS(FB), .CLK_DIV(C), .INHIBIT_FILTER(F)) dut (
        .clk_sys(clk_sys), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .ps2_clk_in(ps2_clk_in), .clr_overflow(clr_overflow),
        .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out),
        .full(full), .level(level), .overflow(overflow), .busy(busy));

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Line decoder: bits are taken at falling edges of the device clock;
    // a high phase longer than a half-bit discards any partial frame.
    typedef struct { logic [10:0] bits; int start; int last_fall; } frame_t;
    frame_t      rxq[$];
    frame_t      mon_f;
    int          mon_n = 0, mon_hi_run = 0, mon_first_fall = 0;
    logic        mon_prev_clk = 1'b1;
    logic [10:0] mon_bits;

    always @(negedge clk_sys) begin
        if (reset) begin
            mon_n = 0; mon_hi_run = 0; mon_prev_clk = 1'b1;
        end else begin
            if (ps2_clk_out === 1'b1) begin
                mon_hi_run++;
                if (mon_hi_run > C) mon_n = 0;
            end else begin
                mon_hi_run = 0;
            end
            if (mon_prev_clk === 1'b1 && ps2_clk_out === 1'b0) begin
                if (mon_n == 0) mon_first_fall = cyc;
                mon_bits[mon_n] = ps2_data_out;
                mon_n++;
                if (mon_n == 11) begin
                    mon_f.bits = mon_bits; mon_f.start = mon_first_fall - C;
                    mon_f.last_fall = cyc; rxq.push_back(mon_f); mon_n = 0;
                end
            end
            mon_prev_clk = ps2_clk_out;
        end
    end

    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return 11'h400 | (((ones % 2) == 0) ? 11'h200 : 11'h000) | (11'(b) << 1);
    endfunction

    task automatic tick();
        @(negedge clk_sys); #1;
    endtask

    task automatic push_byte(input logic [7:0] b, output int edge_cyc);
        wr_en = 1'b1; wr_data = b; tick(); wr_en = 1'b0; edge_cyc = cyc;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && rxq.size() < n; i++) tick();
        ok = (rxq.size() >= n);
    endtask

    task automatic wait_idle(output bit ok);
        for (int i = 0; i < 60 * C && (busy !== 1'b0 || level !== 0); i++) tick();
        ok = (busy === 1'b0 && level === 0);
    endtask

    // Waits until the monitor has taken n bits, then for the next high half.
    task automatic wait_bit_high(input int n, output bit ok);
        int i;
        for (i = 0; i < 40 * C && mon_n != n; i++) tick();
        for (i = 0; i < 2 * C && ps2_clk_out !== 1'b1; i++) tick();
        ok = (mon_n == n && ps2_clk_out === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; repeat (3) tick(); reset = 1'b0; tick();
        vectors++; if (ps2_clk_out !== 1'b1) begin miscompares++; $display("FAIL reset_clk: got %b, expected 1", ps2_clk_out); end
        vectors++; if (ps2_data_out !== 1'b1) begin miscompares++; $display("FAIL reset_data: got %b, expected 1", ps2_data_out); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b, expected 0", full); end
        vectors++; if (level !== 0) begin miscompares++; $display("FAIL reset_level: got %0d, expected 0", level); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_single_frame();
        logic [7:0] pat [3];
        int e, drop; bit ok;
        pat[0] = 8'h1C; pat[1] = 8'($urandom); pat[2] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            rxq.delete();
            push_byte(pat[k], e);
            vectors++; if (level !== 1) begin miscompares++; $display("FAIL push_level: got %0d, expected 1", level); end
            wait_frames(1, 40 * C, ok);
            vectors++;
            if (!ok) begin
                miscompares++; $display("FAIL frame_timeout: got %0d frames, expected 1", rxq.size());
            end else begin
                vectors++; if (rxq[0].bits !== model_frame(pat[k])) begin miscompares++; $display("FAIL frame_bits: got %h, expected %h", rxq[0].bits, model_frame(pat[k])); end
                vectors++; if (rxq[0].start != e + 1) begin miscompares++; $display("FAIL start_latency: got %0d, expected %0d", rxq[0].start, e + 1); end
                vectors++; if (rxq[0].last_fall - rxq[0].start != 21 * C) begin miscompares++; $display("FAIL frame_span: got %0d, expected %0d", rxq[0].last_fall - rxq[0].start, 21 * C); end
                for (int i = 0; i < 4 * C && level !== 0; i++) tick();
                drop = cyc;
                vectors++; if (level !== 0 || drop - rxq[0].start != 22 * C) begin miscompares++; $display("FAIL pop_time: got %0d, expected %0d", drop - rxq[0].start, 22 * C); end
            end
            wait_idle(ok);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp[$];
        logic [7:0] b;
        int fc; bit ok;
        rxq.delete();
        wait_idle(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ovf_idle: got busy %b, expected 0", busy); end
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom); wr_en = 1'b1; wr_data = b; tick();
            if (k < 4) exp.push_back(b);
            if (k == 3) begin
                vectors++; if (full !== 1'b1 || level !== 4) begin miscompares++; $display("FAIL full_after_4: got full %b level %0d, expected 1 4", full, level); end
                vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b, expected 0", overflow); end
            end
        end
        wr_en = 1'b0;
        vectors++; if (overflow !== 1'b1 || level !== 4) begin miscompares++; $display("FAIL ovf_drop: got ovf %b level %0d, expected 1 4", overflow, level); end
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b, expected 0", overflow); end
        clr_overflow = 1'b1; wr_en = 1'b1; wr_data = 8'($urandom); tick(); clr_overflow = 1'b0; wr_en = 1'b0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_clr_and_drop: got %b, expected 1", overflow); end
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear2: got %b, expected 0", overflow); end
        // Push lands on the very edge the head byte pops.
        wait_frames(1, 40 * C, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ovf_first_frame: got %0d frames, expected 1", rxq.size()); end
        fc = ok ? rxq[0].last_fall : cyc;
        for (int i = 0; i < 4 * C && cyc < fc + C - 1; i++) tick();
        b = 8'($urandom); wr_en = 1'b1; wr_data = b; tick(); wr_en = 1'b0;
        exp.push_back(b);
        vectors++; if (level !== 4 || full !== 1'b1) begin miscompares++; $display("FAIL pop_push_level: got level %0d full %b, expected 4 1", level, full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL pop_push_ovf: got %b, expected 0", overflow); end
        wait_frames(5, 6 * 26 * C, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL ovf_frames: got %0d frames, expected 5", rxq.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                vectors++; if (rxq[k].bits !== model_frame(exp[k])) begin miscompares++; $display("FAIL ovf_order[%0d]: got %h, expected %h", k, rxq[k].bits, model_frame(exp[k])); end
                if (k > 0) begin
                    vectors++; if (rxq[k].start - rxq[k-1].start != 24 * C) begin miscompares++; $display("FAIL b2b_period[%0d]: got %0d, expected %0d", k, rxq[k].start - rxq[k-1].start, 24 * C); end
                end
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_inhibit();
        int e, drop; bit ok, lost;
        rxq.delete();
        push_byte(8'hAA, e);
        wait_bit_high(4, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL inh_bit4_wait: got n=%0d, expected 4", mon_n); end
        ps2_clk_in = 1'b0; repeat (10) tick(); ps2_clk_in = 1'b1; repeat (3) tick();
        vectors++; if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1) begin miscompares++; $display("FAIL inh_lines: got %b%b, expected 11", ps2_clk_out, ps2_data_out); end
        vectors++; if (busy !== 1'b1 || level !== 1) begin miscompares++; $display("FAIL inh_state: got busy %b level %0d, expected 1 1", busy, level); end
        vectors++; if (rxq.size() != 0) begin miscompares++; $display("FAIL inh_partial: got %0d frames, expected 0", rxq.size()); end
        lost = 1'b0;
        for (int i = 0; i < 60 * C && rxq.size() == 0; i++) begin
            if (level !== 1) lost = 1'b1;
            tick();
        end
        vectors++; if (lost) begin miscompares++; $display("FAIL inh_level_kept: got a drop, expected level 1"); end
        vectors++;
        if (rxq.size() != 1) begin
            miscompares++; $display("FAIL inh_retx_timeout: got %0d frames, expected 1", rxq.size());
        end else begin
            vectors++; if (rxq[0].bits !== model_frame(8'hAA)) begin miscompares++; $display("FAIL inh_retx_bits: got %h, expected %h", rxq[0].bits, model_frame(8'hAA)); end
            for (int i = 0; i < 4 * C && level !== 0; i++) tick();
            drop = cyc;
            vectors++; if (level !== 0 || drop - rxq[0].start != 22 * C) begin miscompares++; $display("FAIL inh_pop_time: got %0d, expected %0d", drop - rxq[0].start, 22 * C); end
        end
        wait_idle(ok);
    endtask

    task automatic test_inhibit_bit10();
        logic [7:0] b0, b1;
        int e; bit ok, early;
        rxq.delete();
        b0 = 8'($urandom); b1 = 8'($urandom);
        push_byte(b0, e); push_byte(b1, e);
        wait_bit_high(10, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL b10_wait: got n=%0d, expected 10", mon_n); end
        ps2_clk_in = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 12 * C; i++) begin
            tick();
            if (rxq.size() >= 1 && ps2_data_out !== 1'b1) early = 1'b1;
        end
        vectors++; if (rxq.size() != 1) begin miscompares++; $display("FAIL b10_complete: got %0d frames, expected 1", rxq.size()); end
        else begin
            vectors++; if (rxq[0].bits !== model_frame(b0)) begin miscompares++; $display("FAIL b10_bits: got %h, expected %h", rxq[0].bits, model_frame(b0)); end
        end
        vectors++; if (level !== 1) begin miscompares++; $display("FAIL b10_popped: got level %0d, expected 1", level); end
        vectors++; if (early || busy !== 1'b1) begin miscompares++; $display("FAIL b10_held: got early %b busy %b, expected 0 1", early, busy); end
        ps2_clk_in = 1'b1;
        wait_frames(2, 40 * C, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL b10_next_timeout: got %0d frames, expected 2", rxq.size()); end
        else if (rxq[1].bits !== model_frame(b1)) begin miscompares++; $display("FAIL b10_next_bits: got %h, expected %h", rxq[1].bits, model_frame(b1)); end
        wait_idle(ok);
    endtask

    task automatic test_reset_midframe();
        int e; bit ok, stray;
        rxq.delete();
        for (int k = 0; k < 3; k++) push_byte(8'($urandom), e);
        wait_bit_high(6, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rst_bit6_wait: got n=%0d, expected 6", mon_n); end
        reset = 1'b1; tick();
        vectors++; if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1) begin miscompares++; $display("FAIL rst_mid_lines: got %b%b, expected 11", ps2_clk_out, ps2_data_out); end
        vectors++; if (level !== 0 || busy !== 1'b0 || full !== 1'b0) begin miscompares++; $display("FAIL rst_mid_state: got level %0d busy %b full %b, expected 0 0 0", level, busy, full); end
        reset = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 30 * C; i++) begin
            tick();
            if (ps2_data_out !== 1'b1 || ps2_clk_out !== 1'b1) stray = 1'b1;
        end
        vectors++; if (stray || rxq.size() != 0) begin miscompares++; $display("FAIL rst_mid_resume: got activity %b frames %0d, expected 0 0", stray, rxq.size()); end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp[$];
        logic [7:0] b;
        int e; bit ok;
        rxq.delete();
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 24 * C)) tick();
            b = 8'($urandom); push_byte(b, e); exp.push_back(b);
        end
        wait_frames(4, 5 * 26 * C, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rand_timeout: got %0d frames, expected 4", rxq.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                vectors++; if (rxq[k].bits !== model_frame(exp[k])) begin miscompares++; $display("FAIL rand_bits[%0d]: got %h, expected %h", k, rxq[k].bits, model_frame(exp[k])); end
                if (k > 0) begin
                    vectors++; if (rxq[k].start - rxq[k-1].start < 24 * C) begin miscompares++; $display("FAIL rand_spacing[%0d]: got %0d, expected >= %0d", k, rxq[k].start - rxq[k-1].start, 24 * C); end
                end
            end
        end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rand_ovf: got %b, expected 0", overflow); end
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_inhibit();
        test_inhibit_bit10();
        test_reset_midframe();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
